// File: rtl/wb_bus_slice.sv
// Registered pipeline slice between the arbiter and the slave interconnect: a skid-buffered
// request path, registered response path, outstanding-request tracking and a response timeout.
module wb_bus_slice #(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 19,
  parameter int unsigned LGOUT   = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic            i_clk,
  input  logic            i_rst,
  // upstream (arbiter) side
  input  logic            i_cyc,
  input  logic            i_stb,
  input  logic            i_we,
  input  logic [AW-1:0]   i_adr,
  input  logic [DW-1:0]   i_dat,
  input  logic [DW/8-1:0] i_sel,
  output logic            o_stall,
  output logic            o_ack,
  output logic            o_err,
  output logic [DW-1:0]   o_data,
  // downstream (slave interconnect) side
  output logic            o_m_cyc,
  output logic            o_m_stb,
  output logic            o_m_we,
  output logic [AW-1:0]   o_m_adr,
  output logic [DW-1:0]   o_m_dat,
  output logic [DW/8-1:0] o_m_sel,
  input  logic            i_m_stall,
  input  logic            i_m_ack,
  input  logic            i_m_err,
  input  logic [DW-1:0]   i_m_data
);

  localparam int unsigned SW = DW / 8;
  localparam logic [LGOUT-1:0] MaxOut     = '1;
  localparam logic [15:0]      TimeoutVal = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StAbort
  } state_e;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
  } req_t;

  state_e           state_q, state_d;
  logic [LGOUT-1:0] nout_q, nout_d;
  logic [15:0]      timer_q, timer_d;
  logic             skid_vld_q, skid_vld_d;
  req_t             skid_q, skid_d;
  req_t             out_q, out_d;
  logic             stb_q, stb_d;
  logic             cyc_q, cyc_d;
  logic             stall_q, stall_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic [DW-1:0]    data_q;

  req_t in_req;
  logic accept, out_free, busy, live;
  logic fwd_ack, fwd_err, fwd_rsp, timed_out;

  assign in_req = '{we: i_we, adr: i_adr, dat: i_dat, sel: i_sel};

  assign accept   = i_cyc & i_stb & ~stall_q;
  // Output register can take a new request when empty or when its current one issues.
  assign out_free = ~stb_q | ~i_m_stall;
  assign busy     = (state_q == StBusy);

  assign fwd_ack  = i_m_ack & cyc_q & i_cyc & busy;
  assign fwd_err  = i_m_err & cyc_q & i_cyc & busy;
  assign fwd_rsp  = fwd_ack | fwd_err;
  // A response arriving on the expiry clock still counts as a response.
  assign timed_out = busy & i_cyc & (timer_q == TimeoutVal) & ~i_m_ack;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (i_cyc) state_d = StBusy;
      end
      StBusy: begin
        if (!i_cyc) begin
          state_d = StIdle;
        end else if (fwd_err || timed_out) begin
          state_d = StAbort;
        end
      end
      StAbort: begin
        if (!i_cyc) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign live = (state_d == StBusy);

  // Request path: output register backed by a single-entry skid buffer.
  always_comb begin
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    out_d      = out_q;
    stb_d      = stb_q;

    if (out_free) stb_d = 1'b0;

    if (skid_vld_q) begin
      if (out_free) begin
        out_d      = skid_q;
        stb_d      = 1'b1;
        skid_vld_d = 1'b0;
      end
    end else if (accept) begin
      if (out_free) begin
        out_d = in_req;
        stb_d = 1'b1;
      end else begin
        skid_d     = in_req;
        skid_vld_d = 1'b1;
      end
    end

    if (!live) begin
      stb_d      = 1'b0;
      skid_vld_d = 1'b0;
    end
  end

  always_comb begin
    nout_d = nout_q;
    case ({accept, fwd_rsp})
      2'b10:   nout_d = nout_q + 1'b1;
      2'b01:   if (nout_q != '0) nout_d = nout_q - 1'b1;
      default: nout_d = nout_q;
    endcase
    if (!live) nout_d = '0;
  end

  always_comb begin
    timer_d = '0;
    if (busy && live && (nout_q != '0) && !i_m_ack && !i_m_err) begin
      timer_d = (timer_q == TimeoutVal) ? timer_q : timer_q + 16'd1;
    end
  end

  always_comb begin
    stall_d = skid_vld_d | (nout_d == MaxOut) | (state_d == StAbort);
    cyc_d   = live;
    ack_d   = fwd_ack;
    err_d   = fwd_err | timed_out;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      nout_q     <= '0;
      timer_q    <= '0;
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
      out_q      <= '0;
      stb_q      <= 1'b0;
      cyc_q      <= 1'b0;
      stall_q    <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      nout_q     <= nout_d;
      timer_q    <= timer_d;
      skid_vld_q <= skid_vld_d;
      skid_q     <= skid_d;
      out_q      <= out_d;
      stb_q      <= stb_d;
      cyc_q      <= cyc_d;
      stall_q    <= stall_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      data_q     <= i_m_data;
    end
  end

  assign o_stall = stall_q;
  assign o_ack   = ack_q;
  assign o_err   = err_q;
  assign o_data  = data_q;
  assign o_m_cyc = cyc_q;
  assign o_m_stb = stb_q;
  assign o_m_we  = out_q.we;
  assign o_m_adr = out_q.adr;
  assign o_m_dat = out_q.dat;
  assign o_m_sel = out_q.sel;

endmodule

// File: tb/tb_wb_bus_slice.sv
// Bench for wb_bus_slice: directed scenarios plus randomized traffic, checked against a
// transaction-level model (queues of accepted and issued requests, expected responses).
module tb_wb_bus_slice;

  localparam int unsigned DW      = 32;
  localparam int unsigned AW      = 19;
  localparam int unsigned LGOUT   = 2;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned SW      = DW / 8;
  localparam int          MAXOUT  = (1 << LGOUT) - 1;
  localparam int          RW      = 1 + AW + DW + SW;

  typedef logic [RW-1:0] req_t;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_cyc, i_stb, i_we;
  logic [AW-1:0] i_adr;
  logic [DW-1:0] i_dat;
  logic [SW-1:0] i_sel;
  logic          o_stall, o_ack, o_err;
  logic [DW-1:0] o_data;
  logic          o_m_cyc, o_m_stb, o_m_we;
  logic [AW-1:0] o_m_adr;
  logic [DW-1:0] o_m_dat;
  logic [SW-1:0] o_m_sel;
  logic          i_m_stall, i_m_ack, i_m_err;
  logic [DW-1:0] i_m_data;

  always #5 i_clk = ~i_clk;

  wb_bus_slice #(
    .DW     (DW),
    .AW     (AW),
    .LGOUT  (LGOUT),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_cyc    (i_cyc),
    .i_stb    (i_stb),
    .i_we     (i_we),
    .i_adr    (i_adr),
    .i_dat    (i_dat),
    .i_sel    (i_sel),
    .o_stall  (o_stall),
    .o_ack    (o_ack),
    .o_err    (o_err),
    .o_data   (o_data),
    .o_m_cyc  (o_m_cyc),
    .o_m_stb  (o_m_stb),
    .o_m_we   (o_m_we),
    .o_m_adr  (o_m_adr),
    .o_m_dat  (o_m_dat),
    .o_m_sel  (o_m_sel),
    .i_m_stall(i_m_stall),
    .i_m_ack  (i_m_ack),
    .i_m_err  (i_m_err),
    .i_m_data (i_m_data)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Transaction model: requests waiting to be offered, accepted-not-issued, issued-not-answered.
  req_t pend[$];
  req_t acc_q[$];
  req_t iss_q[$];

  logic          cyc_want  = 1'b0;
  logic          ack_en    = 1'b1;
  logic          ack_force = 1'b0;
  logic          err_force = 1'b0;
  logic          use_fix   = 1'b0;
  logic [DW-1:0] fix_data  = 32'hDEADBEEF;
  logic          chk_live  = 1'b1;
  logic          prev_cyc  = 1'b0;
  logic          exp_ack   = 1'b0;
  logic [DW-1:0] exp_data  = '0;
  logic          saw_stall = 1'b0;
  int stb_pct = 100, ack_pct = 100, stall_pct = 0;
  int stall_lo = -1, stall_hi = -1, tick_no = 0;
  int n_acc = 0, n_iss = 0, n_ack = 0;

  function automatic req_t rand_req();
    return {1'($urandom), AW'($urandom), DW'($urandom), SW'($urandom)};
  endfunction

  function automatic req_t out_req();
    return {o_m_we, o_m_adr, o_m_dat, o_m_sel};
  endfunction

  // One clock: check registered results of the previous edge, drive this clock, update the model.
  task automatic tick();
    logic acc, iss, ack;
    check("o_ack", 64'(o_ack), 64'(exp_ack));
    if (exp_ack) check("o_data", 64'(o_data), 64'(exp_data));
    if (chk_live) begin
      check("o_err_quiet", 64'(o_err), 64'(0));
      check("o_m_cyc", 64'(o_m_cyc), 64'(prev_cyc));
    end
    if (acc_q.size() + iss_q.size() == MAXOUT) check("stall_at_max", 64'(o_stall), 64'(1));
    if (o_stall) saw_stall = 1'b1;

    i_cyc = cyc_want;
    i_stb = cyc_want && (pend.size() > 0) && ($urandom_range(99) < stb_pct);
    if (i_stb) {i_we, i_adr, i_dat, i_sel} = pend[0];
    else       {i_we, i_adr, i_dat, i_sel} = rand_req();

    i_m_stall = ($urandom_range(99) < stall_pct) || (tick_no >= stall_lo && tick_no <= stall_hi);
    ack = (iss_q.size() > 0) && ((ack_en && $urandom_range(99) < ack_pct) || ack_force);
    i_m_ack  = ack;
    i_m_err  = err_force;
    i_m_data = use_fix ? fix_data : DW'($urandom);

    acc = i_cyc && i_stb && !o_stall;
    iss = o_m_stb && !i_m_stall;
    exp_ack  = ack && i_cyc;
    exp_data = i_m_data;

    if (ack) begin
      void'(iss_q.pop_front());
      if (i_cyc) n_ack++;
    end
    if (iss) begin
      check("issue_pending", 64'(o_m_stb), 64'(acc_q.size() > 0));
      if (acc_q.size() > 0) begin
        check("issue_req", 64'(out_req()), 64'(acc_q[0]));
        iss_q.push_back(acc_q.pop_front());
        n_iss++;
      end
    end
    if (acc) begin
      acc_q.push_back(pend.pop_front());
      n_acc++;
    end
    if (!i_cyc) begin
      acc_q.delete();
      iss_q.delete();
    end
    prev_cyc = i_cyc;
    @(posedge i_clk);
    #1;
    tick_no++;
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int k;
    k = 0;
    while ((pend.size() + acc_q.size() + iss_q.size() > 0) && k < budget) begin
      tick();
      k++;
    end
    check(tag, 64'(pend.size() + acc_q.size() + iss_q.size()), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int a0, i0, t0;
    i_rst = 1'b1; i_cyc = 1'b0; i_stb = 1'b0; i_we = 1'b0;
    i_adr = '0; i_dat = '0; i_sel = '0;
    i_m_stall = 1'b0; i_m_ack = 1'b0; i_m_err = 1'b0; i_m_data = '0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_ctl", 64'({o_stall, o_ack, o_err, o_m_cyc, o_m_stb, o_m_we}), 64'(0));
    check("rst_adr", 64'(o_m_adr), 64'(0));
    check("rst_dat", 64'({o_m_dat, o_m_sel}), 64'(0));
    check("rst_data", 64'(o_data), 64'(0));
    i_rst = 1'b0;

    // Single read: stb one clock after accept, ack/data one clock after slave ack.
    cyc_want = 1'b1; ack_en = 1'b0;
    pend.push_back({1'b0, 19'h01234, 32'h0, 4'hf});
    tick();
    check("rd_stb_lat", 64'(o_m_stb), 64'(1));
    check("rd_cyc", 64'(o_m_cyc), 64'(1));
    check("rd_adr", 64'(o_m_adr), 64'(19'h01234));
    tick();
    ack_force = 1'b1; use_fix = 1'b1;
    tick();
    ack_force = 1'b0; use_fix = 1'b0;
    check("rd_ack", 64'(o_ack), 64'(1));
    check("rd_data", 64'(o_data), 64'(32'hDEADBEEF));

    // Burst of 8 with downstream stall on clocks 3..5 of the burst.
    ack_en = 1'b1; saw_stall = 1'b0; a0 = n_ack;
    for (int k = 0; k < 8; k++) pend.push_back(rand_req());
    stall_lo = tick_no + 3; stall_hi = tick_no + 5;
    run_until_idle("burst_drain", 100);
    stall_lo = -1; stall_hi = -1;
    check("burst_stall_seen", 64'(saw_stall), 64'(1));
    check("burst_acks", 64'(n_ack - a0), 64'(8));
    tick();
    check("burst_unstall", 64'(o_stall), 64'(0));

    // Outstanding limit: 5 requests, no responses.
    ack_en = 1'b0; a0 = n_acc; i0 = n_iss;
    for (int k = 0; k < 5; k++) pend.push_back(rand_req());
    repeat (8) tick();
    check("max_acc", 64'(n_acc - a0), 64'(MAXOUT));
    check("max_stall", 64'(o_stall), 64'(1));
    ack_en = 1'b1;
    run_until_idle("max_drain", 60);
    check("max_iss", 64'(n_iss - i0), 64'(5));

    // Cycle drop with two outstanding and an ack on the same clock.
    ack_en = 1'b0;
    pend.push_back(rand_req());
    pend.push_back(rand_req());
    repeat (4) tick();
    check("drop_out", 64'(iss_q.size()), 64'(2));
    cyc_want = 1'b0; ack_force = 1'b1;
    tick();
    ack_force = 1'b0;
    check("drop_ack", 64'(o_ack), 64'(0));
    check("drop_cyc", 64'(o_m_cyc), 64'(0));
    cyc_want = 1'b1;
    pend.push_back(rand_req());
    tick();
    check("drop_nout", 64'(o_stall), 64'(0));
    ack_en = 1'b1;
    run_until_idle("drop_drain", 40);

    // Timeout: one request never answered.
    chk_live = 1'b0; ack_en = 1'b0;
    pend.push_back(rand_req());
    tick();
    check("to_issue", 64'(o_m_stb), 64'(1));
    t0 = tick_no;
    for (int k = 0; k < 60 && !o_err; k++) tick();
    check("to_lat", 64'(tick_no - t0), 64'(TIMEOUT + 1));
    check("to_cyc", 64'(o_m_cyc), 64'(0));
    check("to_stall", 64'(o_stall), 64'(1));
    tick();
    check("to_pulse", 64'(o_err), 64'(0));
    repeat (3) tick();
    check("to_hold", 64'(o_stall), 64'(1));
    cyc_want = 1'b0;
    tick();
    check("to_idle", 64'(o_stall), 64'(0));

    // Slave error aborts the cycle.
    cyc_want = 1'b1;
    pend.push_back(rand_req());
    repeat (2) tick();
    err_force = 1'b1;
    tick();
    err_force = 1'b0;
    check("err_fwd", 64'(o_err), 64'(1));
    check("err_cyc", 64'(o_m_cyc), 64'(0));
    tick();
    check("err_pulse", 64'(o_err), 64'(0));
    check("err_stall", 64'(o_stall), 64'(1));
    cyc_want = 1'b0;
    tick();
    chk_live = 1'b1; ack_en = 1'b1;

    // Randomized traffic with occasional one-clock cycle gaps.
    stb_pct = 70; ack_pct = 70; stall_pct = 25;
    for (int k = 0; k < 1500; k++) begin
      if (pend.size() < 4) pend.push_back(rand_req());
      cyc_want = ($urandom_range(99) >= 3);
      tick();
    end
    cyc_want = 1'b1;
    run_until_idle("rand_drain", 200);

    // Reset in the middle of a burst, then a fresh cycle.
    stb_pct = 100; ack_pct = 100; stall_pct = 0;
    for (int k = 0; k < 6; k++) pend.push_back(rand_req());
    repeat (3) tick();
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    check("mrst_ctl", 64'({o_stall, o_ack, o_err, o_m_cyc, o_m_stb, o_m_we}), 64'(0));
    check("mrst_req", 64'({o_m_adr, o_m_sel}), 64'(0));
    check("mrst_dat", 64'(o_m_dat), 64'(0));
    check("mrst_data", 64'(o_data), 64'(0));
    i_rst = 1'b0;
    pend.delete(); acc_q.delete(); iss_q.delete();
    prev_cyc = 1'b0; exp_ack = 1'b0;
    a0 = n_ack;
    pend.push_back(rand_req());
    run_until_idle("mrst_drain", 20);
    tick();
    check("mrst_recover", 64'(n_ack - a0), 64'(1));

    cyc_want = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
